// File: rtl/inst_mem_arbiter.sv
// inst_mem_arbiter: sole controller of the single-ported DEPTH x DATA_W instruction memory.
// The block starts in BOOT, where only the program loader may write. It enters RUN after the
// word flagged ld_last, or after DEPTH words. In RUN the loader and the fetch unit share the
// memory, and fetch read data is returned one cycle after the grant.
//
// Optional feature: define INST_ARB_FAIR_EN to alternate contested grants in RUN.
// Without it, fetch always wins a contested cycle.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   reboot             one-cycle pulse that returns the block to BOOT
//   ld_valid/ld_ready  loader write handshake (ld_addr, ld_data, ld_last)
//   f_req/f_gnt        fetch read handshake (f_addr)
//   f_rvalid/f_rdata   fetch read response, one cycle after the fetch fire
//   boot_done          high in RUN
//   ld_count           words written during the current BOOT, saturating at DEPTH
//   mem_*              memory control, addresses and data
module inst_mem_arbiter #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reboot,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              f_req,
  output logic              f_gnt,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              boot_done,
  output logic [ADDR_W:0]   ld_count,
  output logic              mem_enable,
  output logic              mem_read_writenot,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_in_data,
  input  logic [DATA_W-1:0] mem_out_data
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(DEPTH);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e          state_q;
  logic [ADDR_W:0] ld_count_q;
  logic            f_rvalid_q;
  logic            ld_fire;
  logic            f_fire;
`ifdef INST_ARB_FAIR_EN
  logic            fair_q;  // 0: the next contested grant goes to fetch
`endif

  // Grants are forced low while in reset and during the reboot cycle.
  always_comb begin
    ld_ready = 1'b0;
    f_gnt    = 1'b0;
    if (rst && !reboot) begin
      if (state_q == StBoot) begin
        ld_ready = 1'b1;
      end else begin
`ifdef INST_ARB_FAIR_EN
        if (f_req && ld_valid) begin
          f_gnt    = ~fair_q;
          ld_ready = fair_q;
        end else begin
          f_gnt    = f_req;
          ld_ready = ~f_req;
        end
`else
        f_gnt    = f_req;
        ld_ready = ~f_req;
`endif
      end
    end
  end

  assign ld_fire = ld_valid & ld_ready;
  assign f_fire  = f_req & f_gnt;

  // The grant logic never lets both requesters fire in the same cycle.
  assign mem_enable        = ld_fire | f_fire;
  assign mem_read_writenot = ~ld_fire;
  assign mem_read_address  = f_addr;
  assign mem_write_address = ld_addr;
  assign mem_in_data       = ld_data;

  // Memory data is valid the cycle after the read edge, so it is passed straight through.
  assign f_rdata   = mem_out_data;
  assign f_rvalid  = f_rvalid_q;
  assign boot_done = (state_q == StRun);
  assign ld_count  = ld_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StBoot;
      ld_count_q <= '0;
      f_rvalid_q <= 1'b0;
`ifdef INST_ARB_FAIR_EN
      fair_q     <= 1'b0;
`endif
    end else begin
      // A read fired in the cycle before a reboot still returns its data.
      f_rvalid_q <= f_fire;
      if (reboot) begin
        state_q    <= StBoot;
        ld_count_q <= '0;
`ifdef INST_ARB_FAIR_EN
        fair_q     <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          StBoot: begin
            if (ld_fire) begin
              if (ld_count_q != DepthCnt) begin
                ld_count_q <= ld_count_q + 1'b1;
              end
              if (ld_last || (ld_count_q + 1'b1 == DepthCnt)) begin
                state_q <= StRun;
              end
            end
          end
          StRun: begin
`ifdef INST_ARB_FAIR_EN
            if (f_req && ld_valid) begin
              fair_q <= ~fair_q;
            end
`endif
          end
          default: state_q <= StBoot;
        endcase
      end
    end
  end

endmodule
